// File: rtl/seg7_reader_if.sv
// seg7_reader_if
//   Bundles the scanned display bus and the decoded result of seg7_reader.
//   seg_in  : segment pattern, bit6=a .. bit0=g, active-low
//   dig_sel : slot being driven, 0 = units, 1 = tens
//   value   : last accepted 0..15 value
//   valid   : one-cycle strobe, new value or blank accepted
//   err     : one-cycle strobe, undecodable pair or out-of-range value
//   blank   : level, last accepted pair was blank/blank
//   master  : display-driver / test side (drives the bus, observes results)
//   slave   : reader side (seg7_reader)
interface seg7_reader_if;
  logic [6:0] seg_in;
  logic       dig_sel;
  logic [3:0] value;
  logic       valid;
  logic       err;
  logic       blank;

  modport master (
    output seg_in, dig_sel,
    input  value, valid, err, blank
  );

  modport slave (
    input  seg_in, dig_sel,
    output value, valid, err, blank
  );
endinterface

// File: rtl/seg7_reader.sv
// seg7_reader
//   Recovers a 0..15 value from a scanned two-digit active-low 7-segment bus.
//   A digit is accepted once its pattern and slot have been stable for
//   STABLE_CYCLES samples; units then tens are captured, range-checked and
//   reported with a one-cycle valid or err strobe.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : seg7_reader_if.slave (seg_in, dig_sel in; value, valid, err, blank out)
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  seg7_reader_if.slave  bus
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] ACC_AT  = 8'(STABLE_CYCLES - 2);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_UNITS,
    S_TENS,
    S_OUT
  } state_t;

  typedef struct packed {
    logic       ok;
    logic       blk;
    logic [3:0] val;
  } dec_t;

  function automatic dec_t dec_units(input logic [6:0] p);
    dec_t d;
    d = '{ok: 1'b1, blk: 1'b0, val: 4'd0};
    case (p)
      7'b0000001: d.val = 4'd0;
      7'b1001111: d.val = 4'd1;
      7'b0010010: d.val = 4'd2;
      7'b0000110: d.val = 4'd3;
      7'b1001100: d.val = 4'd4;
      7'b0100100: d.val = 4'd5;
      7'b1100000: d.val = 4'd6;
      7'b0001111: d.val = 4'd7;
      7'b0000000: d.val = 4'd8;
      7'b0001100: d.val = 4'd9;
      7'b1111111: d.blk = 1'b1;
      default:    d.ok  = 1'b0;
    endcase
    return d;
  endfunction

  function automatic dec_t dec_tens(input logic [6:0] p);
    dec_t d;
    d = '{ok: 1'b1, blk: 1'b0, val: 4'd0};
    case (p)
      7'b0000001: d.val = 4'd0;
      7'b1001111: d.val = 4'd1;
      7'b1111111: d.blk = 1'b1;
      default:    d.ok  = 1'b0;
    endcase
    return d;
  endfunction

  logic [6:0] seg_q;
  logic       sel_q;
  logic [7:0] cnt;
  logic       same;
  logic       accept;

  state_t     state;
  logic [6:0] units_q;
  logic [6:0] tens_q;

  dec_t       du;
  dec_t       dt;
  logic [4:0] sum;

  // Pattern and slot are compared together so a simultaneous change is
  // one change.
  assign same   = ({bus.seg_in, bus.dig_sel} == {seg_q, sel_q});
  // Fires only on the cnt STABLE_CYCLES-2 -> STABLE_CYCLES-1 step, so a run
  // that keeps holding does not re-fire.
  assign accept = same && (cnt == ACC_AT);

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      sel_q <= 1'b0;
      cnt   <= '0;
    end else begin
      seg_q <= bus.seg_in;
      sel_q <= bus.dig_sel;
      if (!same)
        cnt <= '0;
      else if (cnt < CNT_MAX)
        cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    du  = dec_units(units_q);
    dt  = dec_tens(tens_q);
    sum = 5'({1'b0, dt.val} * 5'd10) + 5'(du.val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_UNITS;
      units_q   <= SEG_BLANK;
      tens_q    <= SEG_BLANK;
      bus.value <= '0;
      bus.valid <= 1'b0;
      bus.err   <= 1'b0;
      bus.blank <= 1'b1;
    end else begin
      bus.valid <= 1'b0;
      bus.err   <= 1'b0;
      case (state)
        S_UNITS: begin
          if (accept && !sel_q) begin
            units_q <= seg_q;
            state   <= S_TENS;
          end
        end
        S_TENS: begin
          if (accept) begin
            if (sel_q) begin
              tens_q <= seg_q;
              state  <= S_OUT;
            end else begin
              units_q <= seg_q;
            end
          end
        end
        S_OUT: begin
          state <= S_UNITS;
          if (du.blk && dt.blk) begin
            bus.blank <= 1'b1;
            bus.valid <= 1'b1;
          end else if (!du.ok || !dt.ok || du.blk || dt.blk || (sum > 5'd15)) begin
            bus.err <= 1'b1;
          end else begin
            bus.value <= sum[3:0];
            bus.blank <= 1'b0;
            bus.valid <= 1'b1;
          end
        end
        default: state <= S_UNITS;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader
//   Directed self-checking bench for seg7_reader with STABLE_CYCLES=4.
module tb_seg7_reader;

  logic clk;
  logic rst;

  seg7_reader_if bus ();

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) valid_cnt++;
    if (bus.err === 1'b1) err_cnt++;
    if (bus.valid === 1'b1 && bus.err === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] seg, input logic sel, input int n);
    bus.seg_in  = seg;
    bus.dig_sel = sel;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] u, input logic [6:0] t);
    drive(u, 1'b0, 6);
    drive(t, 1'b1, 6);
  endtask

  int vb;
  int eb;

  initial begin
    rst = 1'b1;
    bus.seg_in  = 7'b1111111;
    bus.dig_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", int'(bus.value), 0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_err",   int'(bus.err),   0);
    check("rst_blank", int'(bus.blank), 1);
    rst = 1'b0;

    // 5 + 1*10 = 15
    vb = valid_cnt; eb = err_cnt;
    scan(7'b0100100, 7'b1001111);
    check("v15_valid_pulses", valid_cnt - vb, 1);
    check("v15_err_pulses",   err_cnt - eb,   0);
    check("v15_value", int'(bus.value), 15);
    check("v15_blank", int'(bus.blank), 0);

    // blank / blank
    vb = valid_cnt; eb = err_cnt;
    scan(7'b1111111, 7'b1111111);
    check("blk_valid_pulses", valid_cnt - vb, 1);
    check("blk_err_pulses",   err_cnt - eb,   0);
    check("blk_blank", int'(bus.blank), 1);
    check("blk_value", int'(bus.value), 15);

    // 3 + 10 = 13? no: 13 is in range; use tens=1 units=6 -> 16 out of range
    vb = valid_cnt; eb = err_cnt;
    scan(7'b0000110, 7'b1001111);
    check("u3t1_valid_pulses", valid_cnt - vb, 1);
    check("u3t1_value", int'(bus.value), 13);
    check("u3t1_blank", int'(bus.blank), 0);

    vb = valid_cnt; eb = err_cnt;
    scan(7'b1100000, 7'b1001111);
    check("range_err_pulses",   err_cnt - eb,   1);
    check("range_valid_pulses", valid_cnt - vb, 0);
    check("range_value", int'(bus.value), 13);

    // 8 with a 2-sample glitch of 0 mid-run
    vb = valid_cnt; eb = err_cnt;
    drive(7'b0000000, 1'b0, 3);
    drive(7'b0000001, 1'b0, 2);
    drive(7'b0000000, 1'b0, 6);
    drive(7'b0000001, 1'b1, 6);
    check("glitch_valid_pulses", valid_cnt - vb, 1);
    check("glitch_value", int'(bus.value), 8);

    // undecodable units
    vb = valid_cnt; eb = err_cnt;
    scan(7'b1010101, 7'b0000001);
    check("bad_units_err",   err_cnt - eb,   1);
    check("bad_units_valid", valid_cnt - vb, 0);

    // undecodable tens (a "2" in the tens slot)
    vb = valid_cnt; eb = err_cnt;
    scan(7'b0000001, 7'b0010010);
    check("bad_tens_err",   err_cnt - eb,   1);
    check("bad_tens_value", int'(bus.value), 8);

    // exactly one slot blank
    vb = valid_cnt; eb = err_cnt;
    scan(7'b1111111, 7'b1001111);
    check("one_blank_err",   err_cnt - eb,   1);
    check("one_blank_blank", int'(bus.blank), 0);

    // reset while in S_TENS with units captured
    vb = valid_cnt; eb = err_cnt;
    drive(7'b1001100, 1'b0, 6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_value", int'(bus.value), 0);
    check("mid_rst_blank", int'(bus.blank), 1);
    check("mid_rst_valid", int'(bus.valid), 0);
    drive(7'b0000001, 1'b1, 8);
    check("mid_rst_no_strobe", (valid_cnt - vb) + (err_cnt - eb), 0);

    vb = valid_cnt; eb = err_cnt;
    scan(7'b1001100, 7'b0000001);
    check("post_rst_valid", valid_cnt - vb, 1);
    check("post_rst_value", int'(bus.value), 4);
    check("post_rst_blank", int'(bus.blank), 0);

    check("valid_err_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
